// File: rtl/mdu_hilo.sv
// mdu_hilo: E-stage multiply/divide unit that owns the architectural HI/LO pair.
//   clk, reset (async, active high)
//   req    : exception/interrupt this cycle; cancels the E-stage instruction
//   start  : E-stage instruction is mult/multu/div/divu
//   md_op  : 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 0/7 none
//   A, B   : forwarded rs/rt operands
//   busy   : multi-cycle operation in flight
//   HI, LO : architectural HI/LO registers
module mdu_hilo #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;
  logic [31:0]        hi_tmp_q, hi_tmp_d;
  logic [31:0]        lo_tmp_q, lo_tmp_d;

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic               a_neg, b_neg;
  logic [31:0]        a_mag, b_mag, q_mag, r_mag;
  logic [31:0]        quo_s, rem_s;
  logic [31:0]        res_hi, res_lo;
  logic               is_md;

  // Signed divide runs on magnitudes, then restores signs: quotient truncates
  // toward zero and the remainder follows the dividend. 0x80000000 / -1 falls
  // out naturally as 0x80000000 rem 0.
  always_comb begin
    prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    prod_u = {32'd0, A} * {32'd0, B};
    a_neg  = A[31];
    b_neg  = B[31];
    a_mag  = a_neg ? (~A + 32'd1) : A;
    b_mag  = b_neg ? (~B + 32'd1) : B;
    q_mag  = '0;
    r_mag  = '0;
    if (b_mag != '0) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end
    quo_s  = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    rem_s  = a_neg ? (~r_mag + 32'd1) : r_mag;

    res_hi = hi_q;
    res_lo = lo_q;
    case (md_op)
      3'd1: {res_hi, res_lo} = prod_s;
      3'd2: {res_hi, res_lo} = prod_u;
      3'd3: if (B != '0) begin
        res_hi = rem_s;
        res_lo = quo_s;
      end
      3'd4: if (B != '0) begin
        res_hi = A % B;
        res_lo = A / B;
      end
      default: ;
    endcase
  end

  assign is_md = (md_op >= 3'd1) && (md_op <= 3'd4);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    hi_tmp_d = hi_tmp_q;
    lo_tmp_d = lo_tmp_q;
    case (state_q)
      S_IDLE: begin
        if (!req) begin
          if (start && is_md) begin
            hi_tmp_d = res_hi;
            lo_tmp_d = res_lo;
            cnt_d    = (md_op <= 3'd2) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            busy_d   = 1'b1;
            state_d  = S_BUSY;
          end else if (md_op == 3'd5) begin
            hi_d = A;
          end else if (md_op == 3'd6) begin
            lo_d = A;
          end
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          hi_d    = hi_tmp_q;
          lo_d    = lo_tmp_q;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      hi_tmp_q <= '0;
      lo_tmp_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      hi_tmp_q <= hi_tmp_d;
      lo_tmp_q <= lo_tmp_d;
    end
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Multiply/divide unit with HI/LO registers, in the E stage of the 5-stage MIPS pipeline (P7).
- Executes mult, multu, div, divu, mthi and mtlo. Supplies HI/LO to mfhi/mflo.
- Drives the `busy` status that the hazard unit uses, together with the E-stage `start` strobe, to stall MD/HI-LO instructions in D.
- Honours the exception/interrupt request so that a cancelled E-stage instruction never modifies HI/LO.

Parameters:
- MULT_CYCLES, 5, cycles `busy` stays high for mult/multu (must be >= 1).
- DIV_CYCLES, 10, cycles `busy` stays high for div/divu (must be >= 1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  1  exception/interrupt taken this cycle; the E-stage instruction is cancelled.
- start  input  1  E-stage instruction is mult/multu/div/divu (combinational decode; also fed to the hazard unit).
- md_op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- A  input  32  forwarded GPR[rs].
- B  input  32  forwarded GPR[rt].
- busy  output  1  an operation is in flight.
- HI  output  32  architectural HI register.
- LO  output  32  architectural LO register.

Behaviour:
- Reset (async, takes effect immediately):
  - busy=0, HI=0, LO=0, state=IDLE, counter=0, result temporaries=0.
  - Reset in the middle of an operation aborts it; the result is never written.
- States:
  - IDLE: accepts new operations.
  - BUSY: counter decrements each cycle.
- Issue:
  - Condition: rising edge with state=IDLE, start=1, req=0, md_op in 1..4.
  - Compute the full result from the A/B values present that cycle and latch it into hi_tmp/lo_tmp.
  - Load counter with MULT_CYCLES (ops 1,2) or DIV_CYCLES (ops 3,4); set busy=1; go to BUSY.
- Arithmetic:
  - mult: signed 32x32->64. multu: unsigned 32x32->64. {hi_tmp,lo_tmp} = product.
  - div: signed. lo_tmp=quotient truncated toward zero; hi_tmp=remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo_tmp=0x80000000, hi_tmp=0.
  - divu: unsigned quotient/remainder.
  - Divisor B=0: hi_tmp/lo_tmp take the current HI/LO, so the registers are unchanged after completion. Busy timing is identical to a normal div.
- BUSY:
  - Each edge, counter-1.
  - On the edge where counter==1: HI<=hi_tmp, LO<=lo_tmp, busy<=0, go to IDLE.
  - busy is high for exactly N cycles; new HI/LO are visible in the cycle busy first reads 0.
- In-flight operation is never cancelled by req; it is older than the excepting instruction and must complete.
- mthi/mtlo:
  - Condition: md_op=5/6, req=0, state=IDLE.
  - HI<=A (or LO<=A) at the edge. No busy, single cycle; start is not required.
- Ignored inputs (no state change):
  - start or mthi/mtlo while in BUSY. The hazard unit prevents this; the MDU must still be safe.
  - md_op=0/7.
  - Any op with req=1.
- Outputs HI/LO are registered values only; no bypass of hi_tmp/lo_tmp.
- Back-to-back: an issue may occur on the same edge that busy returns to 0 only if state is already IDLE. The earliest new issue is therefore the edge after completion.

Test Plan:
- multu, A=0xFFFFFFFF, B=2, start=1 for one cycle -> busy=1 for exactly 5 cycles, then HI=0x00000001, LO=0xFFFFFFFE.
- mult, A=0xFFFFFFFD (-3), B=4 -> after 5 cycles HI=0xFFFFFFFF, LO=0xFFFFFFF4.
- div, A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Prior mthi 0x1234 and mtlo 0x5678 (both single-cycle, busy stays 0), then divu with B=0 -> busy 10 cycles, then HI=0x1234, LO=0x5678 unchanged.
- mult with req=1 in the start cycle -> busy stays 0 and HI/LO unchanged. mthi with req=1 -> HI unchanged.
- Issue div, assert reset on cycle 4 -> busy=0, HI=LO=0 immediately; after reset release, mult 3*5 completes normally with LO=15, HI=0.
